// File: rtl/snn_pkg.sv
// Shared SNN core definitions: default geometry and the scheduler state encoding,
// which the core controller also decodes for debug readback.
package snn_pkg;

  localparam int NUM_AXONS_DEF  = 256;
  localparam int AXON_IDX_W_DEF = 8;
  localparam int CNT_W_DEF      = AXON_IDX_W_DEF + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

  // The count must hold NUM_AXONS itself, hence one bit more than an index.
  function automatic int cnt_width(input int idx_w);
    return idx_w + 1;
  endfunction

endpackage

// File: rtl/axon_scheduler.sv
// Per-core axon scheduler: snapshots the input spike vector at timestep start
// and streams the index of every set axon, ascending, over valid/ready.
module axon_scheduler
  import snn_pkg::*;
#(
  parameter int NUM_AXONS  = NUM_AXONS_DEF,
  parameter int AXON_IDX_W = AXON_IDX_W_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start_i,
  input  logic [NUM_AXONS-1:0]  spike_axon_i,
  output logic                  axon_valid_o,
  input  logic                  axon_ready_i,
  output logic [AXON_IDX_W-1:0] axon_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [AXON_IDX_W:0]   spike_count_o
);

  localparam int CNT_W = cnt_width(AXON_IDX_W);
  localparam logic [AXON_IDX_W-1:0] LAST = AXON_IDX_W'(NUM_AXONS - 1);

  sched_state_t          state, state_nxt;
  logic [NUM_AXONS-1:0]  snap, snap_nxt;
  logic [AXON_IDX_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  bit_set;

  // Axon 0 lives in the MSB of the vector.
  assign bit_set = snap[LAST - ptr];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      snap  <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      snap  <= snap_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          snap_nxt  = spike_axon_i;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (bit_set)
          state_nxt = ST_EMIT;
        else if (ptr == LAST)
          state_nxt = ST_DONE;
        else
          ptr_nxt = ptr + 1'b1;
      end
      ST_EMIT: begin
        if (axon_ready_i) begin
          cnt_nxt = cnt + 1'b1;
          if (ptr == LAST) begin
            state_nxt = ST_DONE;
          end else begin
            ptr_nxt   = ptr + 1'b1;
            state_nxt = ST_SCAN;
          end
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode only flopped state, so no input reaches an output combinationally.
  assign axon_valid_o  = (state == ST_EMIT);
  assign axon_idx_o    = axon_valid_o ? ptr : '0;
  assign busy_o        = (state == ST_SCAN) || (state == ST_EMIT);
  assign done_o        = (state == ST_DONE);
  assign spike_count_o = cnt;

endmodule

// File: doc/axon_scheduler.md
# axon_scheduler

Downstream consumer of the per-core 256-bit input spike vector held by the input spike memory. On each timestep start it snapshots the vector, scans axons in ascending index order, and emits one axon index per set bit over a valid/ready stream to the synapse/neuron update stage. One instance per core; it signals completion so the core controller can advance the timestep.

## Interface

**Parameters**
- `NUM_AXONS`, default 256: number of axons, and width of the spike vector.
- `AXON_IDX_W`, default 8: width of the axon index; equals clog2(`NUM_AXONS`).

**Ports**
- `wb_clk_i`  in  1: clock.
- `wb_rst_i`  in  1: reset, asynchronous, active-high.
- `start_i`  in  1: timestep start pulse; sampled only in IDLE.
- `spike_axon_i`  in  `NUM_AXONS`: spike vector; axon n = bit [`NUM_AXONS`-1-n] (axon 0 is the MSB).
- `axon_valid_o`  out  1: an axon event is presented.
- `axon_ready_i`  in  1: consumer accepts the event.
- `axon_idx_o`  out  `AXON_IDX_W`: index of the presented axon.
- `busy_o`  out  1: high in SCAN or EMIT.
- `done_o`  out  1: one-cycle pulse at the end of the scan.
- `spike_count_o`  out  `AXON_IDX_W`+1: number of events accepted since the last start.

## Operation

- **Reset values:** every output is 0. State = IDLE, pointer = 0, snapshot = 0, count = 0.
- **FSM states:** IDLE, SCAN, EMIT, DONE.
- **IDLE:**
  - When `start_i` = 1: latch `spike_axon_i` into the snapshot, set pointer = 0, clear count, go to SCAN.
  - Otherwise stay in IDLE.
- **SCAN:** test snapshot bit for axon[pointer].
  - Bit set: go to EMIT.
  - Bit clear and pointer = `NUM_AXONS`-1: go to DONE.
  - Bit clear otherwise: pointer + 1.
- **EMIT:**
  - `axon_valid_o` = 1 and `axon_idx_o` = pointer; both stay stable until the handshake.
  - On `axon_valid_o` & `axon_ready_i`: count + 1.
  - After the handshake: if pointer = `NUM_AXONS`-1, go to DONE; otherwise pointer + 1 and go to SCAN.
- **DONE:** `done_o` = 1 for this single cycle, then go to IDLE.
- **Snapshot isolation:** Wishbone writes to the spike memory during a scan do not affect the event stream.
- **`start_i` while not IDLE:** ignored, with no side effects.
- **Reset mid-scan:** immediately aborts. No `done_o` and no further events; count clears to 0.
- **Count:** `spike_count_o` holds its final value through IDLE until the next accepted start. It saturates naturally, since the maximum is `NUM_AXONS` (256 fits in 9 bits).
- **`axon_ready_i` outside EMIT:** ignored.
- **Pointer:** never wraps. The scan always terminates at index `NUM_AXONS`-1.

## Timing

- All outputs are registered (Moore); there is no combinational path from an input to an output.
- Let edge E0 be the edge that samples `start_i`. The first SCAN cycle follows E0.
- Each clear bit costs 1 cycle. Each set bit costs 2 cycles plus any ready stall.
- **All-zero vector:** `done_o` is high in the cycle after edge E0+256.
- **m bits set, ready tied high:** `done_o` is high in the cycle after edge E0+256+m.
- **Event ordering:** events appear in strictly ascending index order.
- **Handshake rule:** `axon_valid_o` never deasserts before the handshake completes.
- **`busy_o`:** rises in the cycle after E0 and falls in the DONE cycle.
- **Back-to-back timesteps:** a `start_i` held high through DONE is accepted at the first IDLE edge.

## Structure

- **Shared package `snn_pkg`:**
  - Default `NUM_AXONS` (256) and `AXON_IDX_W` (8).
  - FSM state encoding as a 2-bit enum (IDLE=0, SCAN=1, EMIT=2, DONE=3), shared with the core controller for debug readback.
  - Helper constant for the count width (`AXON_IDX_W`+1).
- **Sub-modules:** none. A single flat module holds the snapshot register, pointer, count and FSM.

## Test plan

- **Reset and idle:** assert `wb_rst_i`, then release with `start_i` = 0 → all outputs 0; no valid over 300 cycles.
- **All-zero vector:** start → zero events; `done_o` one cycle exactly 257 edges after E0; `spike_count_o` = 0.
- **Sparse vector:** axons 0, 37, 255 set (bits 255, 218, 0), ready high → indices 0, 37, 255 in order; `done_o` at E0+260; count = 3.
- **Backpressure:** all 256 bits set, ready toggled randomly → 256 events 0..255 with `axon_idx_o` stable while stalled; count = 256.
- **Snapshot and ignored start:** change `spike_axon_i` and pulse `start_i` mid-scan → emitted set matches the latched vector; no restart.
- **Mid-scan reset:** assert reset while in EMIT at idx 10 → valid drops asynchronously, count = 0, no `done_o`. A new start after release rescans from index 0.
